// File: rtl/operand2_shifter.sv
// rtl/operand2_shifter.sv - ARM-style operand-2 barrel shifter stage with valid/ready handshakes
// Immediate forms resolve in one cycle; register-amount shifts spend an extra SHIFT2 cycle.
module operand2_shifter (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        op2_imm,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic [31:0] rm_val,
  input  logic [1:0]  shift_type,
  input  logic        shift_by_reg,
  input  logic [4:0]  shift_imm5,
  input  logic [31:0] rs_val,
  input  logic        c_flag,
  input  logic [31:0] src1_in,
  input  logic [3:0]  cmd_in,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        src2shift_carry,
  output logic        was_shifted,
  output logic [3:0]  CTRL_cmd
);

  typedef enum logic [1:0] {EMPTY, SHIFT2, FULL} state_t;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;

  state_t      state;
  logic [31:0] rm_q;
  logic [7:0]  rs_q;
  logic [1:0]  st_q;
  logic        c_q;
  logic [31:0] src1_q;
  logic [3:0]  cmd_q;

  logic        in_shift2;
  logic        take;
  logic        go_reg;
  logic [31:0] rm_s;
  logic [1:0]  st_s;
  logic        c_s;

  logic [7:0]  amt;
  logic [7:0]  amt_asr;
  logic [4:0]  rot;
  logic        no_shift;
  logic        rrx;
  logic [63:0] lsl_w;
  logic [63:0] lsr_w;
  logic signed [63:0] asr_in;
  logic signed [63:0] asr_w;
  logic [63:0] ror_w;
  logic [63:0] imm_w;
  logic [31:0] res;
  logic        res_c;
  logic        res_sh;

  logic unused_rs;
  assign unused_rs = ^rs_val[31:8];

  assign in_shift2 = (state == SHIFT2);
  assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready);
  assign out_valid = (state == FULL);
  assign take      = in_valid && in_ready;
  assign go_reg    = shift_by_reg && !op2_imm;

  // In SHIFT2 the shifter works on the latched copy; otherwise on the live inputs.
  assign rm_s = in_shift2 ? rm_q : rm_val;
  assign st_s = in_shift2 ? st_q : shift_type;
  assign c_s  = in_shift2 ? c_q  : c_flag;

  always_comb begin
    amt      = in_shift2 ? rs_q : {3'b000, shift_imm5};
    no_shift = in_shift2 && (rs_q == 8'd0);
    rrx      = 1'b0;
    if (!in_shift2 && (shift_imm5 == 5'd0)) begin
      case (st_s)
        LSL:     no_shift = 1'b1;
        LSR,
        ASR:     amt = 8'd32;
        default: rrx = 1'b1;
      endcase
    end
    amt_asr = (amt > 8'd32) ? 8'd32 : amt;
    rot     = {rot4, 1'b0};
  end

  always_comb begin
    lsl_w  = {32'h0, rm_s} << amt;
    lsr_w  = {rm_s, 32'h0} >> amt;
    asr_in = {rm_s, 32'h0};
    asr_w  = asr_in >>> amt_asr;
    ror_w  = {rm_s, rm_s} >> amt[4:0];
    imm_w  = {24'h0, imm8, 24'h0, imm8} >> rot;
  end

  always_comb begin
    res    = rm_s;
    res_c  = c_s;
    res_sh = 1'b0;
    if (!in_shift2 && op2_imm) begin
      res    = imm_w[31:0];
      res_c  = (rot4 == 4'd0) ? c_flag : imm_w[31];
      res_sh = (rot4 != 4'd0);
    end else if (no_shift) begin
      res    = rm_s;
      res_c  = c_s;
      res_sh = 1'b0;
    end else if (rrx) begin
      res    = {c_s, rm_s[31:1]};
      res_c  = rm_s[0];
      res_sh = 1'b1;
    end else begin
      res_sh = 1'b1;
      case (st_s)
        LSL: begin
          res   = lsl_w[31:0];
          res_c = lsl_w[32];
        end
        LSR: begin
          res   = lsr_w[63:32];
          res_c = lsr_w[31];
        end
        ASR: begin
          res   = asr_w[63:32];
          res_c = asr_w[31];
        end
        default: begin
          res   = ror_w[31:0];
          res_c = ror_w[31];
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= EMPTY;
      src1            <= 32'h0;
      src2            <= 32'h0;
      src2shift_carry <= 1'b0;
      was_shifted     <= 1'b0;
      CTRL_cmd        <= 4'h0;
      rm_q            <= 32'h0;
      rs_q            <= 8'h0;
      st_q            <= 2'b00;
      c_q             <= 1'b0;
      src1_q          <= 32'h0;
      cmd_q           <= 4'h0;
    end else if (in_shift2) begin
      src1            <= src1_q;
      src2            <= res;
      src2shift_carry <= res_c;
      was_shifted     <= res_sh;
      CTRL_cmd        <= cmd_q;
      state           <= FULL;
    end else if (take && go_reg) begin
      rm_q   <= rm_val;
      rs_q   <= rs_val[7:0];
      st_q   <= shift_type;
      c_q    <= c_flag;
      src1_q <= src1_in;
      cmd_q  <= cmd_in;
      state  <= SHIFT2;
    end else if (take) begin
      src1            <= src1_in;
      src2            <= res;
      src2shift_carry <= res_c;
      was_shifted     <= res_sh;
      CTRL_cmd        <= cmd_in;
      state           <= FULL;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end else if (state != FULL) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_operand2_shifter.sv
// tb/tb_operand2_shifter.sv - self-checking bench for operand2_shifter
// A rule-table model feeds a scoreboard checked every cycle; directed vectors pin known answers.
module tb_operand2_shifter;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        op2_imm = 1'b0;
  logic [7:0]  imm8 = 8'h0;
  logic [3:0]  rot4 = 4'h0;
  logic [31:0] rm_val = 32'h0;
  logic [1:0]  shift_type = 2'b00;
  logic        shift_by_reg = 1'b0;
  logic [4:0]  shift_imm5 = 5'h0;
  logic [31:0] rs_val = 32'h0;
  logic        c_flag = 1'b0;
  logic [31:0] src1_in = 32'h0;
  logic [3:0]  cmd_in = 4'h0;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        src2shift_carry;
  logic        was_shifted;
  logic [3:0]  CTRL_cmd;

  operand2_shifter dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .op2_imm(op2_imm), .imm8(imm8), .rot4(rot4), .rm_val(rm_val),
    .shift_type(shift_type), .shift_by_reg(shift_by_reg), .shift_imm5(shift_imm5),
    .rs_val(rs_val), .c_flag(c_flag), .src1_in(src1_in), .cmd_in(cmd_in),
    .src1(src1), .src2(src2), .src2shift_carry(src2shift_carry),
    .was_shifted(was_shifted), .CTRL_cmd(CTRL_cmd)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns {was_shifted, carry, src2} straight from the operand-2 rule tables.
  function automatic logic [33:0] model(input logic imm, input logic [7:0] i8, input logic [3:0] r4,
                                        input logic [31:0] rm, input logic [1:0] st, input logic byreg,
                                        input logic [4:0] n5, input logic [31:0] rs, input logic c);
    logic [31:0] v;
    int r;
    int n;
    int a;
    n = 0;
    if (imm) begin
      v = {24'h0, i8};
      r = 2 * int'(r4);
      if (r == 0) return {1'b0, c, v};
      v = (v >> r) | (v << (32 - r));
      return {1'b1, v[31], v};
    end
    if (byreg) begin
      a = int'(rs[7:0]);
      if (a == 0) return {1'b0, c, rm};
      if (a < 32) n = a;
      else begin
        case (st)
          2'd0: return {1'b1, (a == 32) ? rm[0] : 1'b0, 32'h0};
          2'd1: return {1'b1, (a == 32) ? rm[31] : 1'b0, 32'h0};
          2'd2: return {1'b1, rm[31], {32{rm[31]}}};
          default: begin
            if (a % 32 == 0) return {1'b1, rm[31], rm};
            n = a % 32;
          end
        endcase
      end
    end else begin
      n = int'(n5);
      if (n == 0) begin
        case (st)
          2'd0: return {1'b0, c, rm};
          2'd1: return {1'b1, rm[31], 32'h0};
          2'd2: return {1'b1, rm[31], {32{rm[31]}}};
          default: return {1'b1, rm[0], c, rm[31:1]};
        endcase
      end
    end
    case (st)
      2'd0: return {1'b1, rm[32 - n], rm << n};
      2'd1: return {1'b1, rm[n - 1], rm >> n};
      2'd2: begin
        v = 32'($signed(rm) >>> n);
        return {1'b1, rm[n - 1], v};
      end
      default: begin
        v = (rm >> n) | (rm << (32 - n));
        return {1'b1, rm[n - 1], v};
      end
    endcase
  endfunction

  typedef struct {
    logic [69:0] exp;
    int          rdy;
  } item_t;
  item_t q[$];

  always @(negedge CLOCK_50) begin
    logic  ev;
    logic  er;
    item_t it;
    logic [33:0] m;
    if (!RESET_N) begin
      q.delete();
    end else begin
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      er = (q.size() == 0) ? 1'b1 : ((q[0].rdy > cyc) ? 1'b0 : out_ready);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, er);
      if (ev && out_valid)
        chk("outputs", {src1, src2, src2shift_carry, was_shifted, CTRL_cmd}, q[0].exp);
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        m = model(op2_imm, imm8, rot4, rm_val, shift_type, shift_by_reg, shift_imm5, rs_val, c_flag);
        it.exp = {src1_in, m[31:0], m[32], m[33], cmd_in};
        it.rdy = cyc + ((shift_by_reg && !op2_imm) ? 2 : 1);
        q.push_back(it);
      end
    end
  end

  task automatic vec(input logic imm, input logic [7:0] i8, input logic [3:0] r4, input logic [31:0] rm,
                     input logic [1:0] st, input logic byreg, input logic [4:0] n5, input logic [31:0] rs,
                     input logic c, input logic [31:0] s1, input logic [3:0] cmd);
    op2_imm = imm; imm8 = i8; rot4 = r4; rm_val = rm; shift_type = st;
    shift_by_reg = byreg; shift_imm5 = n5; rs_val = rs; c_flag = c; src1_in = s1; cmd_in = cmd;
  endtask

  task automatic send();
    int  k;
    logic acc;
    k = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    while (!acc && k < 50) begin
      @(negedge CLOCK_50);
      acc = in_ready;
      @(posedge CLOCK_50);
      #1;
      k++;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outputs", {src1, src2, src2shift_carry, was_shifted, CTRL_cmd}, 70'h0);
    RESET_N = 1'b1;

    chk("model_imm_rot", model(1'b1, 8'hFF, 4'd4, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0), {2'b11, 32'hFF000000});
    chk("model_lsr0", model(1'b0, 8'h0, 4'd0, 32'h80000001, 2'd1, 1'b0, 5'd0, 32'h0, 1'b0), {2'b11, 32'h0});
    chk("model_rrx", model(1'b0, 8'h0, 4'd0, 32'h3, 2'd3, 1'b0, 5'd0, 32'h0, 1'b1), {2'b11, 32'h80000001});
    chk("model_reg_lsl33", model(1'b0, 8'h0, 4'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 5'd0, 32'h21, 1'b1), {2'b10, 32'h0});
    chk("model_asr_reg", model(1'b0, 8'h0, 4'd0, 32'h80000000, 2'd2, 1'b1, 5'd0, 32'h4, 1'b0), {2'b10, 32'hF8000000});

    vec(1'b1, 8'hFF, 4'd4, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h11111111, 4'h1);
    send();
    chk("imm_ff_rot8", {out_valid, src2, src2shift_carry, was_shifted}, {1'b1, 32'hFF000000, 2'b11});
    vec(1'b0, 8'h0, 4'd0, 32'h80000001, 2'd1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h2, 4'h2);
    send();
    chk("lsr_0", {out_valid, src2, src2shift_carry, was_shifted}, {1'b1, 32'h0, 2'b11});
    vec(1'b0, 8'h0, 4'd0, 32'h3, 2'd3, 1'b0, 5'd0, 32'h0, 1'b1, 32'h3, 4'h3);
    send();
    chk("rrx", {out_valid, src2, src2shift_carry}, {1'b1, 32'h80000001, 1'b1});
    vec(1'b0, 8'h0, 4'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 5'd0, 32'h21, 1'b1, 32'h4, 4'h4);
    send();
    chk("reg_lsl_shift2", {in_ready, out_valid}, 2'b00);
    @(posedge CLOCK_50);
    #1;
    chk("reg_lsl33", {out_valid, src2, src2shift_carry, was_shifted}, {1'b1, 32'h0, 2'b01});

    vec(1'b1, 8'h5A, 4'd0, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA0, 4'h5); send();
    vec(1'b1, 8'h01, 4'd1, 32'h0, 2'd0, 1'b1, 5'd0, 32'h0, 1'b0, 32'hA1, 4'h6); send();
    vec(1'b0, 8'h0, 4'd0, 32'h12345678, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA2, 4'h7); send();
    vec(1'b0, 8'h0, 4'd0, 32'hF0000001, 2'd0, 1'b0, 5'd4, 32'h0, 1'b0, 32'hA3, 4'h8); send();
    vec(1'b0, 8'h0, 4'd0, 32'h00000003, 2'd1, 1'b0, 5'd1, 32'h0, 1'b0, 32'hA4, 4'h9); send();
    vec(1'b0, 8'h0, 4'd0, 32'h80000000, 2'd2, 1'b0, 5'd0, 32'h0, 1'b0, 32'hA5, 4'hA); send();
    vec(1'b0, 8'h0, 4'd0, 32'h8000001F, 2'd2, 1'b0, 5'd5, 32'h0, 1'b0, 32'hA6, 4'hB); send();
    vec(1'b0, 8'h0, 4'd0, 32'h12345680, 2'd3, 1'b0, 5'd8, 32'h0, 1'b0, 32'hA7, 4'hC); send();
    vec(1'b0, 8'h0, 4'd0, 32'h00000001, 2'd0, 1'b1, 5'd0, 32'h20, 1'b0, 32'hA8, 4'hD); send();
    vec(1'b0, 8'h0, 4'd0, 32'h80000000, 2'd1, 1'b1, 5'd0, 32'h20, 1'b0, 32'hA9, 4'hE); send();
    vec(1'b0, 8'h0, 4'd0, 32'hFFFFFFFF, 2'd1, 1'b1, 5'd0, 32'h28, 1'b1, 32'hAA, 4'hF); send();
    vec(1'b0, 8'h0, 4'd0, 32'h7FFFFFFF, 2'd2, 1'b1, 5'd0, 32'hC8, 1'b1, 32'hAB, 4'h0); send();
    vec(1'b0, 8'h0, 4'd0, 32'h80000001, 2'd3, 1'b1, 5'd0, 32'h40, 1'b0, 32'hAC, 4'h1); send();
    vec(1'b0, 8'h0, 4'd0, 32'h0000000F, 2'd3, 1'b1, 5'd0, 32'h24, 1'b0, 32'hAD, 4'h2); send();
    vec(1'b0, 8'h0, 4'd0, 32'hDEADBEEF, 2'd0, 1'b1, 5'd0, 32'h100, 1'b1, 32'hAE, 4'h3); send();
    vec(1'b0, 8'h0, 4'd0, 32'hDEADBEEF, 2'd1, 1'b1, 5'd0, 32'h3, 1'b0, 32'hAF, 4'h4); send();
    repeat (3) @(posedge CLOCK_50);
    #1;

    out_ready = 1'b0;
    vec(1'b1, 8'h12, 4'd2, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hB0, 4'h5);
    send();
    vec(1'b1, 8'h34, 4'd0, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hB1, 4'h6);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge CLOCK_50);
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", {out_valid, src2, src2shift_carry, was_shifted}, {1'b1, 32'h20000001, 2'b01});
    end
    out_ready = 1'b1;
    c0 = cyc;
    send();
    vec(1'b1, 8'h80, 4'd15, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hB2, 4'h7);
    send();
    vec(1'b1, 8'hC3, 4'd0, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hB3, 4'h8);
    send();
    chk("b2b_cycles", 32'(cyc - c0), 32'd3);

    vec(1'b0, 8'h0, 4'd0, 32'h12345678, 2'd0, 1'b1, 5'd0, 32'h4, 1'b0, 32'hC0, 4'h9);
    send();
    chk("pre_rst_src2", {out_valid, src2}, {1'b0, 32'hC3});
    #1;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst", {out_valid, in_ready, src2, src2shift_carry, src1}, {2'b01, 32'h0, 1'b0, 32'h0});
    @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    repeat (4) begin
      @(posedge CLOCK_50);
      #1;
      chk("post_rst_idle", out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
